// File: rtl/dma_channel_arbiter_pkg.sv
// Shared types and sizing for the DMA channel arbiter.
// Channel count, FSM state enum and index helpers.
package dmaRegConfigPkg;

    localparam int CHANNELS = 4;
    localparam int CHW      = $clog2(CHANNELS);

    typedef logic [CHW-1:0] chIdx_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOLD_WAIT = 2'd1,
        SERVICE   = 2'd2,
        RELEASE   = 2'd3
    } arbState_t;

    function automatic chIdx_t next_idx(input chIdx_t c);
        if (int'(c) == CHANNELS - 1) begin
            return '0;
        end
        return c + 1'b1;
    endfunction

    function automatic logic [CHANNELS-1:0] ch_onehot(input chIdx_t c);
        logic [CHANNELS-1:0] r;
        r    = '0;
        r[c] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/dma_channel_arbiter_if.sv
// DMA bus pin bundle: device requests, hold handshake, acknowledges.
// master = arbiter side, slave = pins / device side.
interface dma_channel_arbiter_if;
    import dmaRegConfigPkg::*;

    logic [CHANNELS-1:0] DREQ;
    logic                HLDA;
    logic                HRQ;
    logic [CHANNELS-1:0] DACK;

    modport master (
        input  DREQ,
        input  HLDA,
        output HRQ,
        output DACK
    );

    modport slave (
        output DREQ,
        output HLDA,
        input  HRQ,
        input  DACK
    );

endinterface

// File: rtl/dma_channel_arbiter_picker.sv
// Combinational round-robin picker: first request at or above ptr,
// wrapping; ptr = 0 gives fixed lowest-index priority.
module dma_rotate_picker
    import dmaRegConfigPkg::*;
(
    input  logic [CHANNELS-1:0] req,
    input  chIdx_t              ptr,
    output chIdx_t              win,
    output logic                valid
);

    int idx;

    // Scan from farthest offset down so the nearest request writes last.
    always_comb begin
        win   = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % CHANNELS;
            if (req[idx]) begin
                valid = 1'b1;
                win   = chIdx_t'(idx);
            end
        end
    end

endmodule

// File: rtl/dma_channel_arbiter.sv
// DMA priority/arbitration unit: DREQ -> HRQ/HLDA -> DACK grant.
// Define DMA_DREQ_SYNC_EN to pass DREQ through a 2-flop synchroniser.
module dma_channel_arbiter
    import dmaRegConfigPkg::*;
(
    input  logic                CLK,
    input  logic                RESET_N,
    dma_channel_arbiter_if.master bus,
    input  logic                cfgEnable,
    input  logic                cfgRotate,
    input  logic                cfgDreqLow,
    input  logic                cfgDackHigh,
    input  logic [CHANNELS-1:0] cfgMask,
    input  logic [CHANNELS-1:0] swReq,
    input  logic                xferDone,
    output logic                grantValid,
    output chIdx_t              grantCh,
    output logic                abortPulse
);

    arbState_t           state;
    arbState_t           state_n;
    logic [CHANNELS-1:0] dreq_s;
    logic [CHANNELS-1:0] req;
    logic [CHANNELS-1:0] onehot;
    chIdx_t              ptr;
    chIdx_t              ptr_eff;
    chIdx_t              win;
    logic                win_valid;
    logic                hrq;
    logic                abort_n;
    logic                done_n;

`ifdef DMA_DREQ_SYNC_EN
    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.DREQ;
            sync2 <= sync1;
        end
    end

    assign dreq_s = sync2;
`else
    assign dreq_s = bus.DREQ;
`endif

    assign req = cfgEnable
               ? (((dreq_s ^ {CHANNELS{cfgDreqLow}}) & ~cfgMask) | swReq)
               : '0;

    assign ptr_eff = cfgRotate ? ptr : '0;

    dma_rotate_picker u_picker (
        .req   (req),
        .ptr   (ptr_eff),
        .win   (win),
        .valid (win_valid)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        abort_n = 1'b0;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req) state_n = HOLD_WAIT;
            end
            HOLD_WAIT: begin
                if (!win_valid) begin
                    state_n = IDLE;
                end else if (bus.HLDA) begin
                    state_n = SERVICE;
                end
            end
            SERVICE: begin
                // Completion wins over a simultaneous HLDA drop.
                if (xferDone) begin
                    state_n = RELEASE;
                    done_n  = 1'b1;
                end else if (!bus.HLDA) begin
                    state_n = IDLE;
                    abort_n = 1'b1;
                end
            end
            RELEASE: begin
                if (!bus.HLDA) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hrq        <= 1'b0;
            grantValid <= 1'b0;
            grantCh    <= '0;
            abortPulse <= 1'b0;
            onehot     <= '0;
            ptr        <= '0;
        end else begin
            hrq        <= (state_n == HOLD_WAIT) || (state_n == SERVICE);
            grantValid <= (state_n == SERVICE);
            abortPulse <= abort_n;
            if (state == HOLD_WAIT && state_n == SERVICE) begin
                grantCh <= win;
            end
            if (state_n != SERVICE) begin
                onehot <= '0;
            end else if (state != SERVICE) begin
                onehot <= ch_onehot(win);
            end
            if (!cfgRotate) begin
                ptr <= '0;
            end else if (done_n) begin
                ptr <= next_idx(grantCh);
            end
        end
    end

    assign bus.HRQ  = hrq;
    assign bus.DACK = cfgDackHigh ? onehot : ~onehot;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Scoreboard bench for dma_channel_arbiter (default build, CHANNELS=4).
module tb_dma_channel_arbiter;
    import dmaRegConfigPkg::*;

    localparam int K_GRANT   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_ABORT   = 2;

    typedef struct {
        int         kind;
        int         ch;
        logic [3:0] dack;
        logic       hrq;
        logic       ab;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       cfgEnable;
    logic       cfgRotate;
    logic       cfgDreqLow;
    logic       cfgDackHigh;
    logic [3:0] cfgMask;
    logic [3:0] swReq;
    logic       xferDone;
    logic       grantValid;
    chIdx_t     grantCh;
    logic       abortPulse;

    int   checks   = 0;
    int   failures = 0;
    exp_t sbq[$];
    logic prev_gv  = 1'b0;

    dma_channel_arbiter_if bus_if ();

    dma_channel_arbiter dut (
        .CLK         (clk),
        .RESET_N     (rst_n),
        .bus         (bus_if.master),
        .cfgEnable   (cfgEnable),
        .cfgRotate   (cfgRotate),
        .cfgDreqLow  (cfgDreqLow),
        .cfgDackHigh (cfgDackHigh),
        .cfgMask     (cfgMask),
        .swReq       (swReq),
        .xferDone    (xferDone),
        .grantValid  (grantValid),
        .grantCh     (grantCh),
        .abortPulse  (abortPulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] dack_on(input int ch);
        logic [3:0] oh;
        oh = 4'b0001 << ch;
        return cfgDackHigh ? oh : ~oh;
    endfunction

    function automatic logic [3:0] dack_off();
        return {4{~cfgDackHigh}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input int ch);
        exp_t e;
        e.kind = kind;
        e.ch   = ch;
        e.dack = (kind == K_GRANT) ? dack_on(ch) : dack_off();
        e.hrq  = (kind == K_GRANT);
        e.ab   = (kind == K_ABORT);
        sbq.push_back(e);
    endtask

    // Monitor: every grantValid edge must match the next queued event.
    always @(negedge clk) begin
        if (rst_n && grantValid !== prev_gv) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=gv%0b required=none",
                         grantValid);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_kind_grant", {31'd0, grantValid},
                    {31'd0, e.kind == K_GRANT});
                if (e.kind == K_GRANT)
                    chk("sb_grant_ch", {30'd0, grantCh}, e.ch);
                chk("sb_dack", {28'd0, bus_if.DACK}, {28'd0, e.dack});
                chk("sb_hrq", {31'd0, bus_if.HRQ}, {31'd0, e.hrq});
                chk("sb_abort", {31'd0, abortPulse}, {31'd0, e.ab});
            end
        end
        prev_gv = grantValid;
    end

    task automatic xfer(input logic [3:0] d, input logic [3:0] s,
                        input int ch, input bit simul);
        bus_if.DREQ = d;
        swReq       = s;
        tick();
        chk("hrq_rise_1cyc", {31'd0, bus_if.HRQ}, 1);
        tick();
        tick();
        chk("hrq_held_no_hlda", {31'd0, bus_if.HRQ}, 1);
        chk("no_dack_before_hlda", {28'd0, bus_if.DACK}, {28'd0, dack_off()});
        bus_if.HLDA = 1'b1;
        push(K_GRANT, ch);
        tick();
        tick();
        tick();
        xferDone    = 1'b1;
        bus_if.DREQ = {4{cfgDreqLow}};
        swReq       = '0;
        if (simul) bus_if.HLDA = 1'b0;
        push(K_RELEASE, ch);
        tick();
        xferDone    = 1'b0;
        bus_if.HLDA = 1'b0;
        tick();
        tick();
        chk("hrq_idle_after", {31'd0, bus_if.HRQ}, 0);
    endtask

    task automatic abort_xfer(input logic [3:0] d, input int ch);
        bus_if.DREQ = d;
        tick();
        bus_if.HLDA = 1'b1;
        push(K_GRANT, ch);
        tick();
        tick();
        push(K_ABORT, ch);
        bus_if.HLDA = 1'b0;
        bus_if.DREQ = {4{cfgDreqLow}};
        tick();
        tick();
        chk("abort_one_cycle", {31'd0, abortPulse}, 0);
        chk("abort_hrq_low", {31'd0, bus_if.HRQ}, 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        cfgEnable   = 1'b1;
        cfgRotate   = 1'b0;
        cfgDreqLow  = 1'b0;
        cfgDackHigh = 1'b0;
        cfgMask     = '0;
        swReq       = '0;
        xferDone    = 1'b0;
        bus_if.DREQ = '0;
        bus_if.HLDA = 1'b0;
        tick();
        tick();
        chk("rst_hrq", {31'd0, bus_if.HRQ}, 0);
        chk("rst_dack", {28'd0, bus_if.DACK}, 32'hF);
        chk("rst_gv", {31'd0, grantValid}, 0);
        chk("rst_gch", {30'd0, grantCh}, 0);
        chk("rst_abort", {31'd0, abortPulse}, 0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_hrq", {31'd0, bus_if.HRQ}, 0);
        chk("idle_dack", {28'd0, bus_if.DACK}, 32'hF);

        xfer(4'b0100, 4'b0000, 2, 1'b0);
        xfer(4'b1010, 4'b0000, 1, 1'b0);

        cfgRotate = 1'b1;
        xfer(4'b0010, 4'b0000, 1, 1'b0);
        xfer(4'b1010, 4'b0000, 3, 1'b0);
        xfer(4'b1010, 4'b0000, 1, 1'b0);

        abort_xfer(4'b1000, 3);
        xfer(4'b1010, 4'b0000, 3, 1'b1);
        xfer(4'b1010, 4'b0000, 1, 1'b0);

        cfgRotate   = 1'b0;
        cfgMask     = 4'b0001;
        bus_if.DREQ = 4'b0001;
        tick();
        tick();
        tick();
        chk("mask_no_hrq", {31'd0, bus_if.HRQ}, 0);
        xfer(4'b0001, 4'b0001, 0, 1'b0);
        cfgMask   = '0;
        cfgEnable = 1'b0;
        swReq     = 4'b0001;
        tick();
        tick();
        chk("disable_no_hrq", {31'd0, bus_if.HRQ}, 0);
        swReq     = '0;
        cfgEnable = 1'b1;
        tick();

        cfgDreqLow  = 1'b1;
        cfgDackHigh = 1'b1;
        bus_if.DREQ = 4'b1111;
        tick();
        tick();
        chk("idle_dack_high", {28'd0, bus_if.DACK}, 0);
        chk("idle_low_dreq_hrq", {31'd0, bus_if.HRQ}, 0);
        xfer(4'b1110, 4'b0000, 0, 1'b0);

        tick();
        tick();
        chk("sb_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
